// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter with held, registered grants.
// An owner keeps the grant for up to weight[i] acked transfers before priority rotates past it.
module wrr_burst_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WEIGHT_W = 3
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*WEIGHT_W-1:0]   weight,
    input  logic                          ack,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
    output logic                          burst_last
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;

    logic [WEIGHT_W-1:0] weight_arr [NUM_REQ];

    logic                owner_req;
    logic                release_now;
    logic                do_arb;
    logic [ID_W-1:0]     next_ptr;
    logic [ID_W-1:0]     arb_ptr;
    logic [ID_W:0]       scan_sum;
    logic [ID_W-1:0]     scan_idx;
    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [WEIGHT_W-1:0] win_weight;
    logic [WEIGHT_W-1:0] credit_load;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_weight
            assign weight_arr[gi] = weight[gi*WEIGHT_W +: WEIGHT_W];
        end
    endgenerate

    always_comb begin
        owner_req   = req[gnt_id_q];
        // An owner that drops its request releases regardless of credit; its ack is ignored.
        release_now = (state_q == OWNED) &&
                      (!owner_req || (ack && (credit_q == WEIGHT_W'(1))));
        do_arb      = (state_q == IDLE) || release_now;
        next_ptr    = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);
        arb_ptr     = release_now ? next_ptr : ptr_q;

        // Cyclic priority search starting at arb_ptr; first set bit wins.
        win_found = 1'b0;
        win_id    = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, arb_ptr} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end

        win_weight  = weight_arr[win_id];
        credit_load = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;

        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        credit_d = credit_q;
        ptr_d    = release_now ? next_ptr : ptr_q;

        if (do_arb) begin
            if (win_found) begin
                state_d  = OWNED;
                gnt_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
                gnt_id_d = win_id;
                credit_d = credit_load;
            end else begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                credit_d = '0;
            end
        end else if ((state_q == OWNED) && ack) begin
            credit_d = credit_q - WEIGHT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            credit_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            credit_q <= credit_d;
            ptr_q    <= ptr_d;
        end
    end

    assign gnt        = gnt_q;
    assign gnt_valid  = (state_q == OWNED);
    assign gnt_id     = gnt_id_q;
    assign burst_last = (state_q == OWNED) && (credit_q == WEIGHT_W'(1));

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Scoreboard bench for wrr_burst_arbiter: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them in the cycle they fall due.
module tb_wrr_burst_arbiter;

    logic        clk;
    logic        rst_b;
    logic [3:0]  req;
    logic [11:0] weight;
    logic        ack;
    logic [3:0]  gnt;
    logic        gnt_valid;
    logic [1:0]  gnt_id;
    logic        burst_last;

    wrr_burst_arbiter #(.NUM_REQ(4), .WEIGHT_W(3)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .req        (req),
        .weight     (weight),
        .ack        (ack),
        .gnt        (gnt),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id),
        .burst_last (burst_last)
    );

    typedef struct {
        int         due;
        logic       v;
        logic [1:0] id;
        logic       last;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [3:0] exp_gnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every expectation whose cycle has come is compared once.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            mon_e   = sb.pop_front();
            exp_gnt = mon_e.v ? (4'b0001 << mon_e.id) : 4'b0000;
            vectors++;
            if (mon_e.due < cyc) begin
                miscompares++;
                $display("FAIL %s: check missed its cycle (due %0d, now %0d)", mon_e.name, mon_e.due, cyc);
            end else if ({gnt_valid, gnt_id, gnt, burst_last} !== {mon_e.v, mon_e.id, exp_gnt, mon_e.last}) begin
                miscompares++;
                $display("FAIL %s: got valid=%b id=%0d gnt=%b last=%b, want valid=%b id=%0d gnt=%b last=%b",
                         mon_e.name, gnt_valid, gnt_id, gnt, burst_last,
                         mon_e.v, mon_e.id, exp_gnt, mon_e.last);
            end else begin
                $display("ok   %s: valid=%b id=%0d gnt=%b last=%b", mon_e.name, gnt_valid, gnt_id, gnt, burst_last);
            end
        end
    end

    // Drive one cycle of inputs; the expectation is for the outputs after the next edge.
    task automatic step(input string name, input logic [3:0] r, input logic a,
                        input logic ev, input logic [1:0] eid, input logic elast);
        exp_t e;
        @(posedge clk);
        #2;
        req = r;
        ack = a;
        e.due = cyc + 1; e.v = ev; e.id = eid; e.last = elast; e.name = name;
        sb.push_back(e);
    endtask

    // Expect all outputs zero within the current cycle (before any further edge).
    task automatic expect_zero_now(input string name);
        exp_t e;
        e.due = cyc; e.v = 1'b0; e.id = 2'd0; e.last = 1'b0; e.name = name;
        sb.push_back(e);
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        drain();
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        req   = 4'b0000;
        ack   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_b = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b  = 1'b0;
        req    = 4'b0000;
        ack    = 1'b0;
        weight = {3'd1, 3'd1, 3'd1, 3'd1};
        @(posedge clk);
        #2;
        expect_zero_now("rst_hold");
        repeat (2) @(posedge clk);
        #2;
        rst_b = 1'b1;

        // 1: idle after reset, then a lone request is granted one cycle later
        for (int i = 0; i < 5; i++) step("t1_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        step("t1_req2",  4'b0100, 1'b0, 1'b1, 2'd2, 1'b1);
        step("t1_drop",  4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        // 2: equal weights, full rotation without bubbles
        do_reset();
        step("t2_g0", 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1);
        step("t2_g1", 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1);
        step("t2_g2", 4'b1111, 1'b1, 1'b1, 2'd2, 1'b1);
        step("t2_g3", 4'b1111, 1'b1, 1'b1, 2'd3, 1'b1);
        step("t2_g0b", 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1);
        step("t2_g1b", 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1);
        step("t2_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        // 3: w0=3, w1=1
        do_reset();
        weight = {3'd1, 3'd1, 3'd1, 3'd3};
        step("t3_0a", 4'b0011, 1'b1, 1'b1, 2'd0, 1'b0);
        step("t3_0b", 4'b0011, 1'b1, 1'b1, 2'd0, 1'b0);
        step("t3_0c", 4'b0011, 1'b1, 1'b1, 2'd0, 1'b1);
        step("t3_1",  4'b0011, 1'b1, 1'b1, 2'd1, 1'b1);
        step("t3_0d", 4'b0011, 1'b1, 1'b1, 2'd0, 1'b0);
        step("t3_0e", 4'b0011, 1'b1, 1'b1, 2'd0, 1'b0);
        step("t3_0f", 4'b0011, 1'b1, 1'b1, 2'd0, 1'b1);
        step("t3_1b", 4'b0011, 1'b1, 1'b1, 2'd1, 1'b1);
        step("t3_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        // 4: backpressure on owner 2 with w2=2
        do_reset();
        weight = {3'd1, 3'd2, 3'd1, 3'd1};
        step("t4_win2", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++) step("t4_stall", 4'b0101, 1'b0, 1'b1, 2'd2, 1'b0);
        step("t4_ack1", 4'b0101, 1'b1, 1'b1, 2'd2, 1'b1);
        step("t4_next0", 4'b0101, 1'b1, 1'b1, 2'd0, 1'b1);
        step("t4_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        // 5a: owner 1 (w1=5) aborts after two acks, requestor 3 takes over
        do_reset();
        weight = {3'd1, 3'd2, 3'd5, 3'd1};
        step("t5_win1", 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
        step("t5_ack1", 4'b1010, 1'b1, 1'b1, 2'd1, 1'b0);
        step("t5_ack2", 4'b1010, 1'b1, 1'b1, 2'd1, 1'b0);
        step("t5_abort", 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1);
        step("t5_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        // 5b: lone requestor 2 re-wins with no bubble
        step("t5_r2a", 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);
        step("t5_r2b", 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1);
        step("t5_r2c", 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);
        step("t5_r2d", 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1);
        step("t5_r2e", 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);
        step("t5_idle2", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        // 6a: weight 0 behaves as a single-beat burst
        do_reset();
        weight = {3'd1, 3'd1, 3'd1, 3'd0};
        step("t6_w0a", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1);
        step("t6_w0b", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1);
        step("t6_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        // 6b: asynchronous reset in the middle of a w3=4 burst
        weight = {3'd4, 3'd1, 3'd1, 3'd1};
        step("t6_win3", 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
        step("t6_ack",  4'b1000, 1'b1, 1'b1, 2'd3, 1'b0);
        step("t6_hold", 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
        drain();
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        req   = 4'b1010;
        ack   = 1'b0;
        expect_zero_now("t6_async_rst");
        @(posedge clk);
        #2;
        rst_b = 1'b1;
        step("t6_after1", 4'b1010, 1'b0, 1'b1, 2'd1, 1'b1);
        step("t6_idle2", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wrr_burst_arbiter.md
Name: wrr_burst_arbiter

Overview:
- Parametrised successor to the team's round-robin arbiter: weighted round-robin with registered, held grants and a per-grant burst credit.
- The winning requestor keeps the grant for up to weight[i] accepted transfers (ack handshakes), then priority rotates past it.
- Sits in front of shared resources (bus ports, memory banks) where masters need multi-beat bursts with fair, weighted bandwidth shares.

Parameters:
- NUM_REQ, 4, number of requestors (>=2).
- WEIGHT_W, 3, width of each per-requestor weight and of the credit counter.

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset; asynchronous, active-low.
- req  in  NUM_REQ  request vector; bit i = requestor i.
- weight  in  NUM_REQ*WEIGHT_W  per-requestor burst weight; field i = weight[i*WEIGHT_W +: WEIGHT_W].
- ack  in  1  downstream accepts one transfer from the current owner this cycle.
- gnt  out  NUM_REQ  registered one-hot grant; all zero when idle.
- gnt_valid  out  1  registered; high when gnt is non-zero.
- gnt_id  out  $clog2(NUM_REQ)  registered encoded owner index; 0 when idle.
- burst_last  out  1  gnt_valid & (credit==1): the next ack ends the grant.

Behaviour:
- Reset (async, rst_b low):
  - gnt=0, gnt_valid=0, gnt_id=0, credit=0, burst_last=0.
  - Priority pointer ptr=0, so requestor 0 has highest priority first.
- States: IDLE (gnt_valid=0) and OWNED (gnt_valid=1).
- Arbitration:
  - Search req cyclically from index ptr upward, wrapping modulo NUM_REQ; the first set bit wins.
  - The winner w is registered at the next clk edge: gnt=1<<w, gnt_id=w, gnt_valid=1.
  - credit loads weight[w] as sampled in the arbitration cycle; weight 0 is treated as 1.
  - ptr is not changed at a win.
- IDLE:
  - If any req bit is set, arbitrate; the grant appears exactly 1 cycle after req is seen.
  - Otherwise stay IDLE.
- OWNED, owner o, req[o]=1, ack=1:
  - If credit>1: credit decrements by 1, grant held, no rotation.
  - If credit==1: release. ptr becomes (o+1) mod NUM_REQ, and arbitration runs in this same cycle with the new ptr using the current req (req[o] included, at lowest priority).
  - A winner is granted at the next edge with no idle bubble. If there is no request, go to IDLE.
- OWNED, ack=0, req[o]=1: all outputs and credit held stable; no timeout.
- OWNED, req[o]=0 (abort):
  - Release at the next edge regardless of credit; ptr becomes (o+1) mod NUM_REQ.
  - Same-cycle re-arbitration, identical to the credit==1 release.
  - ack in an abort cycle is ignored and does not count as a transfer.
- Invariants:
  - gnt always zero or one-hot.
  - gnt only changes at an edge following a release or an IDLE win.
  - Requests from non-owners never pre-empt the owner.
  - weight changes affect only the next load.
- Fairness:
  - Any continuously asserted requestor is granted within (NUM_REQ-1) bursts of other owners.
  - Each owner burst is at most 2^WEIGHT_W-1 accepted transfers.
- Reset mid-burst: the grant drops asynchronously, credit is cleared, ptr returns to 0, and the burst is not resumed.
- ack while gnt_valid=0 is ignored.

Test Plan:
1. Reset: rst_b low then high, req=0 -> gnt=0, gnt_valid=0, gnt_id=0 for 5 cycles. Then req=4'b0100 -> gnt=4'b0100, gnt_id=2 exactly 1 cycle later.
2. Equal weights: weight all 1, req=4'b1111, ack=1 every cycle -> gnt_id sequence 0,1,2,3,0,1 with no idle cycles.
3. Weighted: w0=3, w1=1, req=4'b0011, ack=1 -> gnt_id 0,0,0,1,0,0,0,1. burst_last is high on the 3rd beat of requestor 0 and on every beat of requestor 1.
4. Backpressure: owner 2, w2=2, ack low for 4 cycles then high 2 cycles -> gnt=4'b0100 and credit stable through the stall. Release only after the 2nd ack; the next owner appears on the following cycle.
5. Abort and single requestor:
   - Owner 1 with w1=5 drops req after 2 acks, req3 high -> gnt_id=3 the next cycle.
   - Only req2 high, w2=2 -> gnt_id=2 continuously with no bubble across the re-win.
6. Weight 0 and reset mid-burst:
   - w0=0 -> a single-beat burst.
   - rst_b pulsed low during an owned burst -> gnt=0 immediately. After release with req=4'b1010, the first grant is to requestor 1 (ptr=0).
